// File: rtl/logic_pipe_unit.sv
// Registered N-operand bitwise fold (AND/OR/XOR, inversions, PASS) with valid/ready and multi-beat accumulation.
// Optional beat counter output enabled by LOGIC_PIPE_BEATCNT_EN.
module logic_pipe_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    clkIn,
  input  logic                    rstIn,
  input  logic                    validIn,
  output logic                    readyOut,
  input  logic [NUM_IN*WIDTH-1:0] aIn,
  input  logic [2:0]              opIn,
  input  logic                    accIn,
  input  logic                    lastIn,
  output logic                    validOut,
  input  logic                    readyIn,
  output logic [WIDTH-1:0]        yOut
`ifdef LOGIC_PIPE_BEATCNT_EN
  ,
  output logic [7:0]              beatsOut
`endif
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic             acc_flag_q, acc_flag_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic             in_acc, accept, done;
  logic [2:0]       op_eff;
  logic [WIDTH-1:0] beat_r, merged;

  // Fold one beat's operands with the base op of the code; inversion is deferred to the output.
  function automatic logic [WIDTH-1:0] base_fold(input logic [2:0] op,
                                                 input logic [NUM_IN*WIDTH-1:0] a);
    logic [WIDTH-1:0] r;
    r = a[WIDTH-1:0];
    case (op)
      3'd0, 3'd3: for (int k = 1; k < NUM_IN; k++) r = r & a[k*WIDTH +: WIDTH];
      3'd1, 3'd4: for (int k = 1; k < NUM_IN; k++) r = r | a[k*WIDTH +: WIDTH];
      3'd2, 3'd5: for (int k = 1; k < NUM_IN; k++) r = r ^ a[k*WIDTH +: WIDTH];
      3'd6:       r = a[WIDTH-1:0];
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] combine(input logic [2:0] op,
                                               input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    case (op)
      3'd0, 3'd3: m = acc & r;
      3'd1, 3'd4: m = acc | r;
      3'd2, 3'd5: m = acc ^ r;
      3'd6:       m = r;
      default:    m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] fin_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] f;
    case (op)
      3'd3, 3'd4, 3'd5: f = ~x;
      3'd7:             f = '0;
      default:          f = x;
    endcase
    return f;
  endfunction

  assign readyOut = !valid_q || readyIn;
  assign accept   = validIn && readyOut;
  assign in_acc   = (state_q == ACC) && acc_flag_q;
  // Op and accumulate mode belong to the first beat of a packet.
  assign op_eff   = in_acc ? op_q : opIn;
  assign beat_r   = base_fold(op_eff, aIn);
  assign merged   = in_acc ? combine(op_q, acc_q, beat_r) : beat_r;
  assign done     = accept && (in_acc ? lastIn : (!accIn || lastIn));

`ifdef LOGIC_PIPE_BEATCNT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] beats_q, beats_d;
  logic [7:0] cnt_inc;

  assign cnt_inc = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    op_d       = op_q;
    acc_flag_d = acc_flag_q;
    valid_d    = valid_q;
    y_d        = y_q;
`ifdef LOGIC_PIPE_BEATCNT_EN
    cnt_d      = cnt_q;
    beats_d    = beats_q;
`endif
    if (valid_q && readyIn) valid_d = 1'b0;
    if (accept) begin
      if (done) begin
        valid_d    = 1'b1;
        y_d        = fin_op(op_eff, merged);
        state_d    = IDLE;
        acc_flag_d = 1'b0;
`ifdef LOGIC_PIPE_BEATCNT_EN
        beats_d    = in_acc ? cnt_inc : 8'd1;
`endif
      end else begin
        acc_d   = merged;
        state_d = ACC;
        if (!in_acc) begin
          op_d       = opIn;
          acc_flag_d = 1'b1;
        end
`ifdef LOGIC_PIPE_BEATCNT_EN
        cnt_d = in_acc ? cnt_inc : 8'd1;
`endif
      end
    end
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      op_q       <= '0;
      acc_flag_q <= 1'b0;
      valid_q    <= 1'b0;
      y_q        <= '0;
`ifdef LOGIC_PIPE_BEATCNT_EN
      cnt_q      <= '0;
      beats_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      op_q       <= op_d;
      acc_flag_q <= acc_flag_d;
      valid_q    <= valid_d;
      y_q        <= y_d;
`ifdef LOGIC_PIPE_BEATCNT_EN
      cnt_q      <= cnt_d;
      beats_q    <= beats_d;
`endif
    end
  end

  assign validOut = valid_q;
  assign yOut     = y_q;
`ifdef LOGIC_PIPE_BEATCNT_EN
  assign beatsOut = beats_q;
`endif

endmodule
